cache_write_back: RTL
=====================

# cache_write_back

Direct-mapped, write-back, write-allocate data cache with a parametrised line count and line width. It sits between the core's load/store port and the burst memory controller, which serves PSRAM and flash. Clean misses are refilled by burst; dirty victims are first flushed by burst. Valid and dirty state per line is held in the tag RAM and cleared by a sweep after reset.

## Interface
Parameters:
- `LINE_IX_BITWIDTH`, 8 — log2 of the line count.
- `COLUMN_IX_BITWIDTH`, 2 — log2 of words per line; words are 32 bits.
- `ADDRESS_BITWIDTH`, 32 — width of the byte address. Tag width = `ADDRESS_BITWIDTH - LINE_IX_BITWIDTH - COLUMN_IX_BITWIDTH - 2`.

Ports:
- `clk` in 1 — the only clock.
- `rst` in 1 — reset, synchronous, active-high.
- `cpu_enable` in 1 — request valid. The request must be held stable until `cpu_done`.
- `cpu_address` in `ADDRESS_BITWIDTH` — byte address; bits [1:0] are ignored.
- `cpu_write_enable` in 4 — byte-lane write mask; 0 means read.
- `cpu_data_in` in 32 — write data.
- `cpu_data_out` out 32 — read data, registered.
- `cpu_done` out 1 — one-cycle pulse marking completion.
- `mem_cmd_valid` out 1 — burst command valid.
- `mem_cmd_ready` in 1 — burst command accept.
- `mem_cmd_write` out 1 — 1 = write burst, 0 = read burst.
- `mem_cmd_address` out `ADDRESS_BITWIDTH` — line-aligned burst address.
- `mem_wdata` out 32 — write-burst word.
- `mem_wdata_ready` in 1 — memory accepts the current write word.
- `mem_rdata` in 32 — read-burst word.
- `mem_rdata_valid` in 1 — read word valid; words arrive in column order.

## Operation
- Address split, MSB to LSB: `tag | line_ix | column_ix | 00`.
- Storage:
  - One tag RAM entry per line: `{dirty, valid, tag}`.
  - 2^`COLUMN_IX_BITWIDTH` data banks, each one word wide and `LINE_COUNT` deep, with byte-lane write enables.
  - All RAMs have a one-cycle synchronous read. The read address is the `line_ix` of `cpu_address`, except in INIT, where it is the sweep counter.
- States and transitions:
  - INIT: write tag entry 0 to every line, counter 0..`LINE_COUNT`-1, then go to IDLE. `cpu_enable` is ignored.
  - IDLE: if `cpu_enable` is high and `cpu_done` is low, go to LOOKUP.
  - LOOKUP, hit (valid and tags match):
    - Read: register the word at `column_ix` into `cpu_data_out`.
    - Write: write the masked bytes into the selected bank and set dirty.
    - Pulse `cpu_done`; go to IDLE.
  - LOOKUP, miss with a dirty victim: latch the whole victim line into an eviction buffer, build the victim address from the stored tag, go to EVICT_CMD.
  - LOOKUP, miss otherwise: go to FILL_CMD.
  - EVICT_CMD: `mem_cmd_valid`=1, `mem_cmd_write`=1. On `mem_cmd_ready`, go to EVICT_DATA.
  - EVICT_DATA: drive buffer word k on `mem_wdata`; k advances on `mem_wdata_ready`. After the last word, go to FILL_CMD.
  - FILL_CMD: `mem_cmd_valid`=1, `mem_cmd_write`=0, address = request line. On ready, go to FILL_DATA.
  - FILL_DATA: each `mem_rdata_valid` writes bank k, then k++. With the last word, write the tag as `{dirty=0, valid=1, tag_in}`. Go to SETTLE.
  - SETTLE: one cycle for the RAM read of the refilled line, then go to LOOKUP. LOOKUP now hits, so a write miss merges its bytes after the refill.
- A write hit never touches memory. Only dirty evictions generate write bursts.
- Counter k is `COLUMN_IX_BITWIDTH` wide and is reset to 0 on every entry to EVICT_DATA and FILL_DATA.

## Timing
- Reset, one cycle of `rst`:
  - State becomes INIT; the sweep counter and k become 0.
  - `cpu_done`=0, `cpu_data_out`=0, `mem_cmd_valid`=0, `mem_cmd_write`=0, `mem_cmd_address`=0, `mem_wdata`=0.
- INIT lasts `LINE_COUNT` cycles after reset is released.
- Hit: `cpu_enable` sampled in cycle 0 → LOOKUP in cycle 1 → `cpu_done` and data visible in cycle 2.
- In IDLE, a request is not accepted in a cycle where `cpu_done`=1; the CPU still holds `cpu_enable` in that cycle. The next request is accepted no earlier than cycle 3.
- Clean miss: `mem_cmd_valid` rises in cycle 2.
  - Done = 2 + command wait + N beats + SETTLE + LOOKUP + 1.
- `mem_cmd_valid` and the command fields stay stable until ready. They deassert in the cycle after acceptance.
- `mem_rdata_valid` is accepted in any cycle of FILL_DATA, back-to-back included. It is ignored in other states.
- `rst` mid-burst aborts immediately; the memory controller shares `rst`. A partially filled line stays invalid, because its tag is written only with the last word.

## Structure
- Shared package `cache_pkg`:
  - State enum.
  - Tag-entry layout constants: `LINE_VALID_BIT = TAG_BITWIDTH`, `LINE_DIRTY_BIT = TAG_BITWIDTH + 1`.
  - Address-field width functions.
- Sub-module `cache_ram_bank`: single-port RAM with byte enables and one-cycle read, instantiated once for the tag RAM and once per column.
- The FSM, eviction buffer and address mux stay in `cache_write_back`.

## Test plan
All scenarios use `LINE_IX_BITWIDTH`=2 and `COLUMN_IX_BITWIDTH`=2. The memory model returns word = address.
- Reset, then read 0x10: no `cpu_done` for 4 cycles. Then one read burst at 0x10, 4 beats, and `cpu_data_out`=0x10. A repeat read of 0x14 returns 0x14 with `cpu_done` in cycle 2 and no memory command.
- Write 0xAABBCCDD with mask 0101 to 0x18 (hit after fill). A read of 0x18 returns 0x00BB00DD, with no memory traffic.
- Read 0x50, which maps to the same line with tag 1, after that write: a write burst at 0x10 carries 0x10, 0x14, 0x00BB00DD, 0x1C, then a read burst at 0x50. The result is 0x50.
- Read 0x90, which evicts the clean line: a read burst only, no write burst.
- Hold `mem_wdata_ready` low for 3 cycles on beat 1: `mem_wdata` holds the beat-1 word and k does not advance.
- Assert `rst` during beat 2 of a fill, then read the same address: a full refill burst is issued and the correct data is returned.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address/tag-layout helpers for the write-back data cache.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOOKUP,
        ST_EVICT_CMD,
        ST_EVICT_DATA,
        ST_FILL_CMD,
        ST_FILL_DATA,
        ST_SETTLE
    } cache_state_t;

    localparam int WORD_BITWIDTH = 32;
    localparam int BYTE_OFFSET_BITWIDTH = 2;

    function automatic int tag_bitwidth(input int address_w, input int line_ix_w, input int column_ix_w);
        return address_w - line_ix_w - column_ix_w - BYTE_OFFSET_BITWIDTH;
    endfunction

    function automatic int line_count(input int line_ix_w);
        return 1 << line_ix_w;
    endfunction

    function automatic int column_count(input int column_ix_w);
        return 1 << column_ix_w;
    endfunction

    // Tag entry is {dirty, valid, tag}.
    function automatic int line_valid_bit(input int tag_w);
        return tag_w;
    endfunction

    function automatic int line_dirty_bit(input int tag_w);
        return tag_w + 1;
    endfunction

endpackage

// File: rtl/cache_ram_bank.sv
// Single-port RAM with per-lane write enables and a one-cycle registered read (read-first).
module cache_ram_bank #(
    parameter int ADDR_BITWIDTH = 8,
    parameter int DATA_BITWIDTH = 32,
    parameter int LANE_COUNT    = 4
) (
    input  logic                     clk,
    input  logic [ADDR_BITWIDTH-1:0] address,
    input  logic [LANE_COUNT-1:0]    write_enable,
    input  logic [DATA_BITWIDTH-1:0] write_data,
    output logic [DATA_BITWIDTH-1:0] read_data
);

    localparam int LANE_BITWIDTH = DATA_BITWIDTH / LANE_COUNT;

    logic [DATA_BITWIDTH-1:0] storage [2**ADDR_BITWIDTH];

    always_ff @(posedge clk) begin
        for (int lane = 0; lane < LANE_COUNT; lane++) begin
            if (write_enable[lane]) begin
                storage[address][lane*LANE_BITWIDTH +: LANE_BITWIDTH] <= write_data[lane*LANE_BITWIDTH +: LANE_BITWIDTH];
            end
        end
        read_data <= storage[address];
    end

endmodule

// File: rtl/cache_write_back.sv
// Direct-mapped write-back, write-allocate data cache between the core load/store
// port and the burst memory controller.
module cache_write_back
    import cache_pkg::*;
#(
    parameter int LINE_IX_BITWIDTH   = 8,
    parameter int COLUMN_IX_BITWIDTH = 2,
    parameter int ADDRESS_BITWIDTH   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cpu_enable,
    input  logic [ADDRESS_BITWIDTH-1:0] cpu_address,
    input  logic [3:0]                  cpu_write_enable,
    input  logic [31:0]                 cpu_data_in,
    output logic [31:0]                 cpu_data_out,
    output logic                        cpu_done,
    output logic                        mem_cmd_valid,
    input  logic                        mem_cmd_ready,
    output logic                        mem_cmd_write,
    output logic [ADDRESS_BITWIDTH-1:0] mem_cmd_address,
    output logic [31:0]                 mem_wdata,
    input  logic                        mem_wdata_ready,
    input  logic [31:0]                 mem_rdata,
    input  logic                        mem_rdata_valid
);

    localparam int TAG_BITWIDTH   = tag_bitwidth(ADDRESS_BITWIDTH, LINE_IX_BITWIDTH, COLUMN_IX_BITWIDTH);
    localparam int COLUMN_COUNT   = column_count(COLUMN_IX_BITWIDTH);
    localparam int LINE_VALID_BIT = line_valid_bit(TAG_BITWIDTH);
    localparam int LINE_DIRTY_BIT = line_dirty_bit(TAG_BITWIDTH);
    localparam int ENTRY_BITWIDTH = TAG_BITWIDTH + 2;
    localparam int OFFSET_BITWIDTH = COLUMN_IX_BITWIDTH + BYTE_OFFSET_BITWIDTH;

    cache_state_t state;

    logic [LINE_IX_BITWIDTH-1:0]   sweep;
    logic [COLUMN_IX_BITWIDTH-1:0] k;
    logic [COLUMN_IX_BITWIDTH-1:0] k_next;

    logic [TAG_BITWIDTH-1:0]       tag_in;
    logic [LINE_IX_BITWIDTH-1:0]   line_ix;
    logic [COLUMN_IX_BITWIDTH-1:0] column_ix;
    logic [LINE_IX_BITWIDTH-1:0]   ram_address;
    logic                          is_read;

    logic [ENTRY_BITWIDTH-1:0]     tag_rdata;
    logic [ENTRY_BITWIDTH-1:0]     tag_wdata;
    logic                          tag_we;
    logic                          hit;
    logic                          victim_dirty;

    logic [31:0]                   bank_rdata [COLUMN_COUNT];
    logic [3:0]                    bank_we    [COLUMN_COUNT];
    logic [31:0]                   bank_wdata;
    logic [31:0]                   evict_buf  [COLUMN_COUNT];

    logic [ADDRESS_BITWIDTH-1:0]   fill_address;
    logic [ADDRESS_BITWIDTH-1:0]   victim_address;

    logic                          unused_byte_offset;

    assign tag_in    = cpu_address[ADDRESS_BITWIDTH-1 -: TAG_BITWIDTH];
    assign line_ix   = cpu_address[OFFSET_BITWIDTH +: LINE_IX_BITWIDTH];
    assign column_ix = cpu_address[BYTE_OFFSET_BITWIDTH +: COLUMN_IX_BITWIDTH];
    assign is_read   = (cpu_write_enable == 4'b0000);
    assign k_next    = k + 1'b1;

    assign unused_byte_offset = ^cpu_address[BYTE_OFFSET_BITWIDTH-1:0];

    assign ram_address = (state == ST_INIT) ? sweep : line_ix;

    assign hit          = tag_rdata[LINE_VALID_BIT] && (tag_rdata[TAG_BITWIDTH-1:0] == tag_in);
    assign victim_dirty = tag_rdata[LINE_VALID_BIT] && tag_rdata[LINE_DIRTY_BIT];

    assign fill_address   = {tag_in, line_ix, {OFFSET_BITWIDTH{1'b0}}};
    assign victim_address = {tag_rdata[TAG_BITWIDTH-1:0], line_ix, {OFFSET_BITWIDTH{1'b0}}};

    // Only a LOOKUP write hit takes CPU data; every other bank write is a refill beat.
    assign bank_wdata = (state == ST_LOOKUP) ? cpu_data_in : mem_rdata;

    cache_ram_bank #(
        .ADDR_BITWIDTH(LINE_IX_BITWIDTH),
        .DATA_BITWIDTH(ENTRY_BITWIDTH),
        .LANE_COUNT   (1)
    ) tag_ram (
        .clk         (clk),
        .address     (ram_address),
        .write_enable(tag_we),
        .write_data  (tag_wdata),
        .read_data   (tag_rdata)
    );

    for (genvar c = 0; c < COLUMN_COUNT; c++) begin : g_bank
        cache_ram_bank #(
            .ADDR_BITWIDTH(LINE_IX_BITWIDTH),
            .DATA_BITWIDTH(32),
            .LANE_COUNT   (4)
        ) data_ram (
            .clk         (clk),
            .address     (ram_address),
            .write_enable(bank_we[c]),
            .write_data  (bank_wdata),
            .read_data   (bank_rdata[c])
        );
    end

    always_comb begin
        tag_we    = 1'b0;
        tag_wdata = '0;
        for (int c = 0; c < COLUMN_COUNT; c++) begin
            bank_we[c] = 4'b0000;
        end
        if (!rst) begin
            case (state)
                ST_INIT: begin
                    tag_we = 1'b1;
                end
                ST_LOOKUP: begin
                    if (hit && !is_read) begin
                        bank_we[column_ix]             = cpu_write_enable;
                        tag_we                         = 1'b1;
                        tag_wdata[TAG_BITWIDTH-1:0]    = tag_in;
                        tag_wdata[LINE_VALID_BIT]      = 1'b1;
                        tag_wdata[LINE_DIRTY_BIT]      = 1'b1;
                    end
                end
                ST_FILL_DATA: begin
                    if (mem_rdata_valid) begin
                        bank_we[k] = 4'b1111;
                        // The tag goes valid only with the final beat, so an aborted refill leaves the line invalid.
                        if (k == '1) begin
                            tag_we                      = 1'b1;
                            tag_wdata[TAG_BITWIDTH-1:0] = tag_in;
                            tag_wdata[LINE_VALID_BIT]   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_LOOKUP && !hit && victim_dirty) begin
            for (int c = 0; c < COLUMN_COUNT; c++) begin
                evict_buf[c] <= bank_rdata[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_INIT;
            sweep           <= '0;
            k               <= '0;
            cpu_done        <= 1'b0;
            cpu_data_out    <= '0;
            mem_cmd_valid   <= 1'b0;
            mem_cmd_write   <= 1'b0;
            mem_cmd_address <= '0;
            mem_wdata       <= '0;
        end else begin
            cpu_done <= 1'b0;
            case (state)
                ST_INIT: begin
                    sweep <= sweep + 1'b1;
                    if (sweep == '1) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    // The CPU still holds its finished request during the done pulse.
                    if (cpu_enable && !cpu_done) begin
                        state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        if (is_read) begin
                            cpu_data_out <= bank_rdata[column_ix];
                        end
                        cpu_done <= 1'b1;
                        state    <= ST_IDLE;
                    end else if (victim_dirty) begin
                        mem_cmd_valid   <= 1'b1;
                        mem_cmd_write   <= 1'b1;
                        mem_cmd_address <= victim_address;
                        state           <= ST_EVICT_CMD;
                    end else begin
                        mem_cmd_valid   <= 1'b1;
                        mem_cmd_write   <= 1'b0;
                        mem_cmd_address <= fill_address;
                        state           <= ST_FILL_CMD;
                    end
                end
                ST_EVICT_CMD: begin
                    if (mem_cmd_ready) begin
                        mem_cmd_valid <= 1'b0;
                        k             <= '0;
                        mem_wdata     <= evict_buf[0];
                        state         <= ST_EVICT_DATA;
                    end
                end
                ST_EVICT_DATA: begin
                    if (mem_wdata_ready) begin
                        if (k == '1) begin
                            mem_cmd_valid   <= 1'b1;
                            mem_cmd_write   <= 1'b0;
                            mem_cmd_address <= fill_address;
                            state           <= ST_FILL_CMD;
                        end else begin
                            k         <= k_next;
                            mem_wdata <= evict_buf[k_next];
                        end
                    end
                end
                ST_FILL_CMD: begin
                    if (mem_cmd_ready) begin
                        mem_cmd_valid <= 1'b0;
                        k             <= '0;
                        state         <= ST_FILL_DATA;
                    end
                end
                ST_FILL_DATA: begin
                    if (mem_rdata_valid) begin
                        k <= k_next;
                        if (k == '1) begin
                            state <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    // Refilled line is being read out of the RAMs; LOOKUP then hits.
                    state <= ST_LOOKUP;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule
